// File: rtl/ppu_issue_ctrl_pkg.sv
// Shared encodings for the posit processing unit (PPU) issue path.
// The instruction decoder, the issue controller and the tracer all import this package.
package ppu_issue_ctrl_pkg;

  localparam logic [6:0] OPCODE_PPU_OP = 7'b0101011;
  localparam logic [6:0] PPU_FUNCT7    = 7'b1101010;

  localparam logic [2:0] PPU_F3_ADD = 3'b000;
  localparam logic [2:0] PPU_F3_SUB = 3'b001;
  localparam logic [2:0] PPU_F3_MUL = 3'b010;
  localparam logic [2:0] PPU_F3_DIV = 3'b100;

  typedef enum logic [1:0] {
    PPU_ADD = 2'd0,
    PPU_SUB = 2'd1,
    PPU_MUL = 2'd2,
    PPU_DIV = 2'd3
  } ppu_op_e;

endpackage

// File: rtl/ppu_instr_decode.sv
// Purely combinational decode of a PPU-OP instruction word.
// The tracer reuses this block, so it has no state and no handshake logic.
module ppu_instr_decode
  import ppu_issue_ctrl_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic        is_ppu_o,
  output logic        legal_o,
  output ppu_op_e     op_o,
  output logic [4:0]  rd_o
);

  logic f3_ok;
  logic unused_rs;

  // The rs1/rs2 fields are not needed: operand values arrive already read from the register file.
  assign unused_rs = ^instr_i[24:15];

  always_comb begin
    is_ppu_o = (instr_i[6:0] == OPCODE_PPU_OP);
    rd_o     = instr_i[11:7];
    op_o     = PPU_ADD;
    f3_ok    = 1'b1;
    case (instr_i[14:12])
      PPU_F3_ADD: op_o = PPU_ADD;
      PPU_F3_SUB: op_o = PPU_SUB;
      PPU_F3_MUL: op_o = PPU_MUL;
      PPU_F3_DIV: op_o = PPU_DIV;
      default:    f3_ok = 1'b0;
    endcase
    legal_o = is_ppu_o && f3_ok && (instr_i[31:25] == PPU_FUNCT7);
  end

endmodule

// File: rtl/ppu_issue_ctrl.sv
// Issues PPU-OP instructions from the ID stage to the PPU, stalls the pipeline while an operation is in flight,
// and writes the result back to the register file.
//
// state | meaning
// IDLE  | waiting for a PPU-OP in ID
// REQ   | ppu_req_o high, operands held until the PPU grants
// WAIT  | granted, counting cycles until rvalid or timeout
// WB    | one-cycle register file write (suppressed if rd==x0 or the op was discarded)
module ppu_issue_ctrl
  import ppu_issue_ctrl_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid_i,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            illegal_ppu_o,
  output logic            ppu_req_o,
  input  logic            ppu_gnt_i,
  output ppu_op_e         ppu_op_o,
  output logic [XLEN-1:0] ppu_a_o,
  output logic [XLEN-1:0] ppu_b_o,
  input  logic            ppu_rvalid_i,
  input  logic [XLEN-1:0] ppu_result_i,
  output logic            wb_we_o,
  output logic [4:0]      wb_addr_o,
  output logic [XLEN-1:0] wb_wdata_o,
  output logic            busy_o,
  output logic            timeout_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_WB} state_e;

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic            discard_q;
  ppu_op_e         op_q;
  logic [XLEN-1:0] a_q, b_q, result_q;
  logic [4:0]      rd_q;
  logic            timeout_q;

  logic            dec_is_ppu, dec_legal;
  ppu_op_e         dec_op;
  logic [4:0]      dec_rd;

  logic accept, latch_res, timeout_hit;
  logic cnt_clr, cnt_inc, set_discard, clr_discard;

  ppu_instr_decode u_decode (
    .instr_i  (instr_i),
    .is_ppu_o (dec_is_ppu),
    .legal_o  (dec_legal),
    .op_o     (dec_op),
    .rd_o     (dec_rd)
  );

  always_comb begin
    state_d       = state_q;
    stall_o       = 1'b0;
    illegal_ppu_o = 1'b0;
    ppu_req_o     = 1'b0;
    wb_we_o       = 1'b0;
    accept        = 1'b0;
    latch_res     = 1'b0;
    timeout_hit   = 1'b0;
    cnt_clr       = 1'b0;
    cnt_inc       = 1'b0;
    set_discard   = 1'b0;
    clr_discard   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (id_valid_i && dec_is_ppu && !flush_i) begin
          if (dec_legal) begin
            accept  = 1'b1;
            stall_o = 1'b1;
            state_d = S_REQ;
          end else begin
            illegal_ppu_o = 1'b1;
          end
        end
      end
      S_REQ: begin
        ppu_req_o = 1'b1;
        stall_o   = 1'b1;
        if (ppu_gnt_i) begin
          // Once granted the PPU will answer, so a flush only marks the result for discard.
          state_d     = S_WAIT;
          cnt_clr     = 1'b1;
          set_discard = flush_i;
        end else if (flush_i) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        stall_o     = 1'b1;
        set_discard = flush_i;
        if (ppu_rvalid_i) begin
          latch_res = 1'b1;
          state_d   = S_WB;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_hit = 1'b1;
          clr_discard = 1'b1;
          state_d     = S_IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_WB: begin
        wb_we_o     = (rd_q != 5'd0) && !discard_q;
        clr_discard = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      discard_q <= 1'b0;
      op_q      <= PPU_ADD;
      a_q       <= '0;
      b_q       <= '0;
      rd_q      <= '0;
      result_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timeout_q <= timeout_hit;
      if (cnt_clr)
        cnt_q <= '0;
      else if (cnt_inc && cnt_q != CNT_W'(TIMEOUT_CYCLES))
        cnt_q <= cnt_q + CNT_W'(1);
      if (clr_discard)
        discard_q <= 1'b0;
      else if (set_discard)
        discard_q <= 1'b1;
      if (accept) begin
        op_q <= dec_op;
        a_q  <= op_a_i;
        b_q  <= op_b_i;
        rd_q <= dec_rd;
      end
      if (latch_res)
        result_q <= ppu_result_i;
    end
  end

  assign ppu_op_o   = op_q;
  assign ppu_a_o    = a_q;
  assign ppu_b_o    = b_q;
  assign wb_addr_o  = rd_q;
  assign wb_wdata_o = result_q;
  assign busy_o     = (state_q != S_IDLE);
  assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_ppu_issue_ctrl.sv
// Bench for ppu_issue_ctrl: a table of instruction vectors plus hand-written flush, timeout and reset sequences.
// Expected register-file writes go into a queue and are popped when wb_we_o fires.
module tb_ppu_issue_ctrl;
  import ppu_issue_ctrl_pkg::*;

  localparam int XLEN = 32;
  localparam int TO   = 64;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            id_valid_i, flush_i, ppu_gnt_i, ppu_rvalid_i;
  logic [31:0]     instr_i;
  logic [XLEN-1:0] op_a_i, op_b_i, ppu_result_i;
  logic            stall_o, illegal_ppu_o, ppu_req_o, wb_we_o, busy_o, timeout_o;
  logic [1:0]      ppu_op_o;
  logic [XLEN-1:0] ppu_a_o, ppu_b_o, wb_wdata_o;
  logic [4:0]      wb_addr_o;

  ppu_issue_ctrl #(.XLEN(XLEN), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid_i), .instr_i(instr_i),
    .op_a_i(op_a_i), .op_b_i(op_b_i), .flush_i(flush_i), .stall_o(stall_o),
    .illegal_ppu_o(illegal_ppu_o), .ppu_req_o(ppu_req_o), .ppu_gnt_i(ppu_gnt_i),
    .ppu_op_o(ppu_op_o), .ppu_a_o(ppu_a_o), .ppu_b_o(ppu_b_o),
    .ppu_rvalid_i(ppu_rvalid_i), .ppu_result_i(ppu_result_i), .wb_we_o(wb_we_o),
    .wb_addr_o(wb_addr_o), .wb_wdata_o(wb_wdata_o), .busy_o(busy_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_t;
  wb_t sb[$];

  typedef struct {
    logic [31:0]     instr;
    logic [XLEN-1:0] a, b, res;
    int              gnt_dly, rv_dly;
    bit              legal;
    bit              exp_illegal;
    logic [1:0]      op;
    bit              wb;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3,
                                     input logic [4:0] rd, input logic [6:0] opc);
    return {f7, 5'd2, 5'd1, f3, rd, opc};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_valid_i = 0; instr_i = '0; op_a_i = '0; op_b_i = '0; flush_i = 0;
    ppu_gnt_i = 0; ppu_rvalid_i = 0; ppu_result_i = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"}, stall_o, 0);
    chk({tag, "_illegal"}, illegal_ppu_o, 0);
    chk({tag, "_req"}, ppu_req_o, 0);
    chk({tag, "_op"}, ppu_op_o, 0);
    chk({tag, "_a"}, ppu_a_o, 0);
    chk({tag, "_b"}, ppu_b_o, 0);
    chk({tag, "_we"}, wb_we_o, 0);
    chk({tag, "_addr"}, wb_addr_o, 0);
    chk({tag, "_wdata"}, wb_wdata_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_timeout"}, timeout_o, 0);
  endtask

  // Register-file write monitor: every write must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && wb_we_o) begin
      if (sb.size() == 0) begin
        chk("wb_unexpected", {59'd0, wb_addr_o}, 64'hFFFF);
      end else begin
        wb_t e;
        e = sb.pop_front();
        chk("wb_addr", wb_addr_o, e.rd);
        chk("wb_data", wb_wdata_o, e.data);
      end
    end
  end

  // Accept cycle, then REQ for gnt_dly+1 cycles, WAIT for rv_dly+1 cycles, then WB.
  task automatic do_txn(input vec_t v);
    id_valid_i = 1; instr_i = v.instr; op_a_i = v.a; op_b_i = v.b;
    @(negedge clk);
    chk("acc_stall", stall_o, 1);
    chk("acc_illegal", illegal_ppu_o, 0);
    chk("acc_req", ppu_req_o, 0);
    cyc();
    idle_inputs();
    for (int i = 0; i <= v.gnt_dly; i++) begin
      if (i == v.gnt_dly) ppu_gnt_i = 1;
      @(negedge clk);
      chk("req_req", ppu_req_o, 1);
      chk("req_op", ppu_op_o, v.op);
      chk("req_a", ppu_a_o, v.a);
      chk("req_b", ppu_b_o, v.b);
      chk("req_stall", stall_o, 1);
      cyc();
    end
    ppu_gnt_i = 0;
    for (int i = 0; i <= v.rv_dly; i++) begin
      if (i == v.rv_dly) begin
        ppu_rvalid_i = 1; ppu_result_i = v.res;
        if (v.wb) sb.push_back('{rd: v.instr[11:7], data: v.res});
      end
      @(negedge clk);
      chk("wait_req", ppu_req_o, 0);
      chk("wait_stall", stall_o, 1);
      chk("wait_timeout", timeout_o, 0);
      cyc();
    end
    ppu_rvalid_i = 0; ppu_result_i = '0;
    @(negedge clk);
    chk("wb_we", wb_we_o, v.wb);
    chk("wb_stall", stall_o, 0);
    chk("wb_busy", busy_o, 1);
    cyc();
    @(negedge clk);
    chk("post_busy", busy_o, 0);
    chk("post_we", wb_we_o, 0);
    cyc();
  endtask

  task automatic do_idle_instr(input vec_t v);
    id_valid_i = 1; instr_i = v.instr; op_a_i = v.a; op_b_i = v.b;
    @(negedge clk);
    chk("ill_pulse", illegal_ppu_o, v.exp_illegal);
    chk("ill_stall", stall_o, 0);
    chk("ill_req", ppu_req_o, 0);
    cyc();
    idle_inputs();
    @(negedge clk);
    chk("ill_busy", busy_o, 0);
    chk("ill_req2", ppu_req_o, 0);
    chk("ill_pulse_end", illegal_ppu_o, 0);
    cyc();
  endtask

  // Accept a legal ADD to rd, present gnt with an optional flush, and leave the DUT in WAIT.
  task automatic start_to_wait(input logic [4:0] rd, input bit flush_on_gnt);
    id_valid_i = 1; instr_i = mk(PPU_FUNCT7, PPU_F3_ADD, rd, OPCODE_PPU_OP);
    op_a_i = 32'h1111_0000; op_b_i = 32'h0000_2222;
    cyc();
    idle_inputs();
    ppu_gnt_i = 1; flush_i = flush_on_gnt;
    cyc();
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs.push_back('{mk(PPU_FUNCT7, PPU_F3_ADD, 5'd5, OPCODE_PPU_OP), 32'h4000_0000, 32'h4000_0000,
                     32'h4800_0000, 0, 0, 1, 0, 2'd0, 1});
    vecs.push_back('{mk(PPU_FUNCT7, PPU_F3_DIV, 5'd7, OPCODE_PPU_OP), 32'h3800_0000, 32'h5000_0000,
                     32'h2A55_AA55, 5, 9, 1, 0, 2'd3, 1});
    vecs.push_back('{mk(PPU_FUNCT7, PPU_F3_SUB, 5'd12, OPCODE_PPU_OP), 32'hDEAD_BEEF, 32'h0123_4567,
                     32'hCAFE_F00D, 1, 2, 1, 0, 2'd1, 1});
    vecs.push_back('{mk(PPU_FUNCT7, PPU_F3_MUL, 5'd31, OPCODE_PPU_OP), 32'h8000_0001, 32'h7FFF_FFFF,
                     32'h1234_5678, 2, 0, 1, 0, 2'd2, 1});
    vecs.push_back('{mk(PPU_FUNCT7, PPU_F3_ADD, 5'd0, OPCODE_PPU_OP), 32'hAAAA_AAAA, 32'h5555_5555,
                     32'h9999_9999, 0, 1, 1, 0, 2'd0, 0});
    vecs.push_back('{mk(7'b1101011, PPU_F3_ADD, 5'd3, OPCODE_PPU_OP), 32'h1, 32'h2, 32'h0,
                     0, 0, 0, 1, 2'd0, 0});
    vecs.push_back('{mk(PPU_FUNCT7, 3'b011, 5'd3, OPCODE_PPU_OP), 32'h1, 32'h2, 32'h0,
                     0, 0, 0, 1, 2'd0, 0});
    vecs.push_back('{mk(PPU_FUNCT7, 3'b111, 5'd4, OPCODE_PPU_OP), 32'h1, 32'h2, 32'h0,
                     0, 0, 0, 1, 2'd0, 0});
    vecs.push_back('{mk(PPU_FUNCT7, PPU_F3_ADD, 5'd6, 7'b0110011), 32'h1, 32'h2, 32'h0,
                     0, 0, 0, 0, 2'd0, 0});

    idle_inputs();
    rst_n = 0;
    #12;
    chk_all_zero("rst");
    cyc();
    rst_n = 1;
    cyc();

    foreach (vecs[i]) begin
      if (vecs[i].legal) do_txn(vecs[i]);
      else do_idle_instr(vecs[i]);
    end

    // Flush while requesting without grant: request drops, no write.
    id_valid_i = 1; instr_i = mk(PPU_FUNCT7, PPU_F3_MUL, 5'd9, OPCODE_PPU_OP);
    op_a_i = 32'h0F0F_0F0F; op_b_i = 32'hF0F0_F0F0;
    cyc();
    idle_inputs();
    flush_i = 1;
    @(negedge clk);
    chk("flreq_req", ppu_req_o, 1);
    cyc();
    idle_inputs();
    ppu_rvalid_i = 1; ppu_result_i = 32'h7777_7777;
    @(negedge clk);
    chk("flreq_req_drop", ppu_req_o, 0);
    chk("flreq_busy", busy_o, 0);
    cyc();
    idle_inputs();

    // Flush in WAIT: the result drains but is not written.
    start_to_wait(5'd10, 1'b0);
    flush_i = 1;
    @(negedge clk);
    chk("flwait_stall", stall_o, 1);
    cyc();
    idle_inputs();
    ppu_rvalid_i = 1; ppu_result_i = 32'h3333_4444;
    cyc();
    idle_inputs();
    @(negedge clk);
    chk("flwait_we", wb_we_o, 0);
    chk("flwait_busy", busy_o, 1);
    cyc();
    @(negedge clk);
    chk("flwait_idle", busy_o, 0);
    cyc();

    // Flush coincident with grant: still waits, result discarded.
    start_to_wait(5'd11, 1'b1);
    ppu_rvalid_i = 1; ppu_result_i = 32'h5555_6666;
    @(negedge clk);
    chk("flgnt_busy", busy_o, 1);
    cyc();
    idle_inputs();
    @(negedge clk);
    chk("flgnt_we", wb_we_o, 0);
    cyc();

    // Discard must not leak into the next operation.
    do_txn('{mk(PPU_FUNCT7, PPU_F3_SUB, 5'd13, OPCODE_PPU_OP), 32'h1, 32'h2,
             32'hBEEF_0013, 0, 0, 1, 0, 2'd1, 1});

    // Timeout: 64 WAIT cycles without rvalid, pulse in the following cycle.
    start_to_wait(5'd14, 1'b0);
    for (int i = 1; i <= TO; i++) begin
      @(negedge clk);
      chk("to_pending", timeout_o, 0);
      chk("to_busy", busy_o, 1);
      cyc();
    end
    @(negedge clk);
    chk("to_pulse", timeout_o, 1);
    chk("to_idle", busy_o, 0);
    chk("to_we", wb_we_o, 0);
    cyc();
    ppu_rvalid_i = 1; ppu_result_i = 32'hBAD0_0001;
    @(negedge clk);
    chk("to_pulse_end", timeout_o, 0);
    chk("to_stray_busy", busy_o, 0);
    cyc();
    idle_inputs();
    @(negedge clk);
    chk("to_stray_we", wb_we_o, 0);
    chk("to_stray_busy2", busy_o, 0);
    cyc();

    // Asynchronous reset during WAIT, then a late rvalid.
    start_to_wait(5'd15, 1'b0);
    @(negedge clk);
    chk("rstw_busy", busy_o, 1);
    #1 rst_n = 0;
    #1 chk_all_zero("rstw");
    cyc();
    rst_n = 1;
    ppu_rvalid_i = 1; ppu_result_i = 32'hBAD0_0002;
    cyc();
    idle_inputs();
    @(negedge clk);
    chk("rstw_late_we", wb_we_o, 0);
    chk("rstw_late_busy", busy_o, 0);
    cyc();
    repeat (2) cyc();

    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
